bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_if.sv | 24 ++
 rtl/bram_port_arbiter.sv | 78 +++++++
 tb/tb_bram_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: two-requester command/response bundle plus the shared BRAM port.
// m0_lock/m1_lock exist only when BRAM_ARB_LOCK_EN is defined.
interface bram_port_arbiter_if;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] BRAM_addr, BRAM_din, BRAM_dout;
  logic [3:0]  BRAM_we;
  logic        BRAM_en, BRAM_rst, BRAM_clk;
`ifdef BRAM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
  modport master(output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, m0_lock, m1_lock, BRAM_dout,
                 input m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, BRAM_addr, BRAM_din, BRAM_we, BRAM_en, BRAM_rst, BRAM_clk);
  modport slave(input m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, m0_lock, m1_lock, BRAM_dout,
                output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, BRAM_addr, BRAM_din, BRAM_we, BRAM_en, BRAM_rst, BRAM_clk);
`else
  modport master(output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, BRAM_dout,
                 input m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, BRAM_addr, BRAM_din, BRAM_we, BRAM_en, BRAM_rst, BRAM_clk);
  modport slave(input m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata, BRAM_dout,
                output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, BRAM_addr, BRAM_din, BRAM_we, BRAM_en, BRAM_rst, BRAM_clk);
`endif
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port between two requesters with read-tag pipeline.
// Optional BRAM_ARB_LOCK_EN adds per-requester lock for exclusive ownership.
module bram_port_arbiter #(
  parameter int RD_LATENCY     = 2,
  parameter int ADDR_INC_CHECK = 0
) (
  input logic clk,
  input logic rst,
  bram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAST0, LAST1} state_e;
  state_e                state_q, state_d;
  logic                  g0, g1, blk0, blk1;
  logic [31:0]           addr_w, din_w;
  logic [3:0]            we_w;
  logic                  en_q, brst_q;
  logic [3:0]            we_q;
  logic [31:0]           addr_q, din_q;
  logic [RD_LATENCY-1:0] vld_q, own_q;
`ifdef BRAM_ARB_LOCK_EN
  logic [1:0] lk_q, lk_d;
  assign blk0 = lk_q[1] & bus.m1_req;
  assign blk1 = lk_q[0] & bus.m0_req;
  always_comb begin
    lk_d[0] = g0 ? bus.m0_lock : lk_q[0] & bus.m0_req;
    lk_d[1] = g1 ? bus.m1_lock : lk_q[1] & bus.m1_req;
  end
  always_ff @(posedge clk) lk_q <= rst ? 2'b00 : lk_d;
`else
  assign blk0 = 1'b0;
  assign blk1 = 1'b0;
`endif
  // m1 wins a tie only right after m0 owned the port; a lock overrides the tie-break
  always_comb begin
    g0      = !rst & bus.m0_req & !blk0 & (!bus.m1_req | blk1 | state_q != LAST0);
    g1      = !rst & bus.m1_req & !blk1 & (!bus.m0_req | blk0 | state_q == LAST0);
    state_d = g0 ? LAST0 : g1 ? LAST1 : IDLE;
    addr_w  = g1 ? bus.m1_addr : bus.m0_addr;
    addr_w  = ADDR_INC_CHECK != 0 ? {addr_w[31:2], 2'b00} : addr_w;
    din_w   = g1 ? bus.m1_wdata : bus.m0_wdata;
    we_w    = g1 ? bus.m1_we : bus.m0_we;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= 32'h0;
      din_q   <= 32'h0;
      brst_q  <= 1'b1;
      vld_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= g0 | g1;
      we_q    <= (g0 | g1) ? we_w : 4'h0;
      brst_q  <= 1'b0;
      vld_q   <= (vld_q << 1) | RD_LATENCY'((g0 | g1) && we_w == 4'h0);
      own_q   <= (own_q << 1) | RD_LATENCY'(g1);
      if (g0 | g1) begin
        addr_q <= addr_w;
        din_q  <= din_w;
      end
    end
  end
  assign bus.m0_gnt    = g0;
  assign bus.m1_gnt    = g1;
  assign bus.m0_rvalid = !rst & vld_q[RD_LATENCY-1] & !own_q[RD_LATENCY-1];
  assign bus.m1_rvalid = !rst & vld_q[RD_LATENCY-1] & own_q[RD_LATENCY-1];
  assign bus.m0_rdata  = bus.BRAM_dout;
  assign bus.m1_rdata  = bus.BRAM_dout;
  assign bus.BRAM_addr = addr_q;
  assign bus.BRAM_din  = din_q;
  assign bus.BRAM_we   = we_q;
  assign bus.BRAM_en   = en_q;
  assign bus.BRAM_rst  = brst_q;
  assign bus.BRAM_clk  = clk;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scenarios plus randomized traffic checked against a cycle-indexed
// behavioural model of the arbitration rules, BRAM port registers and read-return schedule.
module tb_bram_port_arbiter;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bram_port_arbiter_if bus();
  bram_port_arbiter #(.RD_LATENCY(L)) dut(.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, passes = 0, cyc = 0;
  int last = 0, lockown = 0, win = -1, rv, g1_seen = 0;
  int rv_at[0:8191];
  int gseq[$];
  bit model_ok = 0;
  logic exp_en, exp_brst;
  logic [3:0] exp_we;
  logic [31:0] exp_addr, exp_din, dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
  endtask

  function automatic int winner();
    if (rst) return -1;
`ifdef BRAM_ARB_LOCK_EN
    if (lockown == 1 && bus.m0_req) return 0;
    if (lockown == 2 && bus.m1_req) return 1;
`endif
    if (bus.m0_req && bus.m1_req) return (last == 1) ? 1 : 0;
    if (bus.m0_req) return 0;
    if (bus.m1_req) return 1;
    return -1;
  endfunction

  task automatic tick();
    logic lk;
    @(negedge clk);
    win = winner();
    chk("gnt0", bus.m0_gnt, win == 0);
    chk("gnt1", bus.m1_gnt, win == 1);
    if (bus.m1_gnt) g1_seen++;
    rv = rst ? 0 : rv_at[cyc];
    chk("rvalid0", bus.m0_rvalid, rv == 1);
    chk("rvalid1", bus.m1_rvalid, rv == 2);
    if (rv != 0) chk("rdata", rv == 1 ? bus.m0_rdata : bus.m1_rdata, dout);
    chk("bram_clk_lo", bus.BRAM_clk, 1'b0);
    if (model_ok) begin
      chk("bram_en", bus.BRAM_en, exp_en);
      chk("bram_we", bus.BRAM_we, exp_we);
      chk("bram_addr", bus.BRAM_addr, exp_addr);
      chk("bram_din", bus.BRAM_din, exp_din);
      chk("bram_rst", bus.BRAM_rst, exp_brst);
    end
    if (rst) begin
      last = 0; lockown = 0; exp_en = 0; exp_we = 0; exp_addr = 0; exp_din = 0; exp_brst = 1; model_ok = 1;
      for (int k = cyc + 1; k <= cyc + L; k++) rv_at[k] = 0;
    end else begin
      exp_brst = 0;
      if (win >= 0) begin
        exp_en   = 1;
        exp_we   = win ? bus.m1_we : bus.m0_we;
        exp_addr = win ? bus.m1_addr : bus.m0_addr;
        exp_din  = win ? bus.m1_wdata : bus.m0_wdata;
        last     = win + 1;
        if (exp_we == 0) rv_at[cyc + L] = win + 1;
        gseq.push_back(win);
`ifdef BRAM_ARB_LOCK_EN
        lk = win ? bus.m1_lock : bus.m0_lock;
`else
        lk = 1'b0;
`endif
        if (lk) lockown = win + 1;
        else if (lockown == win + 1) lockown = 0;
      end else begin
        exp_en = 0; exp_we = 0; last = 0;
      end
      if ((lockown == 1 && !bus.m0_req) || (lockown == 2 && !bus.m1_req)) lockown = 0;
    end
    @(posedge clk);
    #1;
    chk("bram_clk_hi", bus.BRAM_clk, 1'b1);
    cyc++;
    dout = $urandom;
    bus.BRAM_dout = dout;
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) rv_at[k] = 0;
    rst = 1;
    {bus.m0_req, bus.m1_req} = 2'b00;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_we = 0; bus.m1_we = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
`ifdef BRAM_ARB_LOCK_EN
    bus.m0_lock = 0; bus.m1_lock = 0;
`endif
    dout = 32'h0; bus.BRAM_dout = dout;
    tick(); tick();
    rst = 0;
    tick();
    // single m0 read of 0x10
    bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_we = 0;
    tick();
    chk("rd_gnt_same_cycle", win, 0);
    bus.m0_req = 0;
    for (int i = 0; i < 4; i++) tick();
    // both requesters hold reads for six cycles
    gseq.delete();
    bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 0; bus.m1_we = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (win == 0) bus.m0_addr = bus.m0_addr + 4;
      if (win == 1) bus.m1_addr = bus.m1_addr + 4;
    end
    bus.m0_req = 0; bus.m1_req = 0;
    for (int i = 0; i < 6; i++) chk("alternate", gseq[i], i % 2);
    for (int i = 0; i < L + 1; i++) tick();
    // m1 partial write
    bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_we = 4'b0011; bus.m1_wdata = 32'hDEADBEEF;
    tick();
    bus.m1_req = 0; bus.m1_we = 0;
    for (int i = 0; i < L + 2; i++) tick();
    // reset one cycle after a read accept discards the read
    bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_we = 0;
    tick();
    bus.m0_req = 0; rst = 1;
    tick();
    rst = 0;
    tick(); tick();
    bus.m0_req = 1; bus.m1_req = 1; bus.m1_we = 0;
    tick();
    chk("tie_after_rst", gseq[$], 0);
    bus.m0_req = 0; bus.m1_req = 0;
    for (int i = 0; i < L + 1; i++) tick();
`ifdef BRAM_ARB_LOCK_EN
    // m0 three locked reads then one unlocked; m1 requesting throughout
    bus.m1_req = 1; bus.m1_we = 0; bus.m0_req = 1; bus.m0_we = 0;
    g1_seen = 0;
    for (int n = 0; n < 4; n++) begin
      bus.m0_lock = (n < 3);
      tick();
      chk("lock_m0_gnt", win, 0);
      bus.m0_addr = bus.m0_addr + 4;
    end
    chk("lock_m1_blocked", g1_seen, 0);
    bus.m0_lock = 0;
    tick();
    chk("lock_m1_after", win, 1);
    bus.m0_req = 0; bus.m1_req = 0;
    for (int i = 0; i < L + 1; i++) tick();
`endif
    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!bus.m0_req || win == 0) begin
        bus.m0_req = $urandom_range(0, 9) < 7;
        bus.m0_addr = 32'($urandom_range(0, 1023)) << 2;
        bus.m0_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        bus.m0_wdata = $urandom;
`ifdef BRAM_ARB_LOCK_EN
        bus.m0_lock = ($urandom_range(0, 3) == 0);
`endif
      end
      if (!bus.m1_req || win == 1) begin
        bus.m1_req = $urandom_range(0, 9) < 7;
        bus.m1_addr = 32'($urandom_range(0, 1023)) << 2;
        bus.m1_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        bus.m1_wdata = $urandom;
`ifdef BRAM_ARB_LOCK_EN
        bus.m1_lock = ($urandom_range(0, 3) == 0);
`endif
      end
      tick();
    end
    rst = 0; bus.m0_req = 0; bus.m1_req = 0;
    for (int i = 0; i < L + 2; i++) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
